async_fifo_wr_if: RTL and testbench

Producer-side front end for the async FIFO write controller, in the wr_clk domain. Accepts an AXI-Stream-style beat stream (tdata/tlast/tvalid/tready) through a 2-entry skid buffer. Drives wr_en/wr_data into the FIFO write port, using the controller's registered wr_full and fifo_cnt_wr_synced for backpressure and status. Provides a registered s_tready, a programmable almost-full flag and beat/packet counters.

---
 rtl/async_fifo_wr_if.sv | 80 ++++++++
 tb/tb_async_fifo_wr_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_if.sv
// Producer-side front end of the async FIFO write path: 2-entry skid buffer feeding the
// FIFO write port, registered ready, programmable almost-full and beat/packet counters.
module async_fifo_wr_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PROG_FULL  = DEPTH - 1
) (
  input  logic                    wr_clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    wr_full,
  input  logic [$clog2(DEPTH):0]  fifo_cnt_wr_synced,
  output logic                    wr_en,
  output logic [DATA_WIDTH:0]     wr_data,
  output logic                    prog_full,
  output logic [31:0]             beat_cnt,
  output logic [15:0]             pkt_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic [DATA_WIDTH:0] out_q, skid_q, in_beat;
  logic                accept, fire;

  assign in_beat = {s_tlast, s_tdata};
  assign accept  = s_tvalid & s_tready;
  // wr_full already reflects any write in flight, so writing whenever it is low is safe
  assign fire    = (state_q != StEmpty) & ~wr_full & ~rst;
  assign wr_en   = fire;
  assign wr_data = out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !fire)      state_d = StTwo;
        else if (!accept && fire) state_d = StEmpty;
      end
      StTwo:   if (fire) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      s_tready  <= 1'b0;
      prog_full <= 1'b0;
      beat_cnt  <= 32'd0;
      pkt_cnt   <= 16'd0;
    end else begin
      state_q   <= state_d;
      s_tready  <= (state_d != StTwo);
      prog_full <= (fifo_cnt_wr_synced >= CntW'(PROG_FULL));
      if (fire) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (out_q[DATA_WIDTH]) pkt_cnt <= pkt_cnt + 16'd1;
      end
      case (state_q)
        StEmpty: if (accept) out_q <= in_beat;
        StOne: begin
          if (accept) begin
            if (fire) out_q  <= in_beat;
            else      skid_q <= in_beat;
          end
        end
        StTwo:   if (fire) out_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_if.sv
// Self-checking bench for async_fifo_wr_if: directed corner cases, a prog_full vector
// table and a randomized run against a queue-based model of the buffer.
module tb_async_fifo_wr_if;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int PF    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          wr_full = 1'b0;
  logic [CW-1:0] fifo_cnt_wr_synced = '0;
  logic          wr_en;
  logic [DW:0]   wr_data;
  logic          prog_full;
  logic [31:0]   beat_cnt;
  logic [15:0]   pkt_cnt;

  async_fifo_wr_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PROG_FULL(PF)) dut (
    .wr_clk(wr_clk), .rst(rst), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .wr_full(wr_full), .fifo_cnt_wr_synced(fifo_cnt_wr_synced),
    .wr_en(wr_en), .wr_data(wr_data), .prog_full(prog_full), .beat_cnt(beat_cnt),
    .pkt_cnt(pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Model: beats held inside the block, in acceptance order
  logic [DW:0] mbuf[$];
  logic [DW:0] wr_log[$];
  int          acc_total = 0;
  logic        m_tready = 1'b0;
  logic        m_prog = 1'b0;
  logic [31:0] m_beats = '0;
  logic [15:0] m_pkts = '0;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          exp_pf;
  } pf_vec_t;
  pf_vec_t pf_tab[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge with inputs already driven; advances one clock.
  task automatic step();
    logic fire, acc;
    #1;
    fire = (mbuf.size() > 0) && !wr_full && !rst;
    check("wr_en", wr_en, fire);
    check("s_tready", s_tready, m_tready);
    check("prog_full", prog_full, m_prog);
    check("beat_cnt", beat_cnt, m_beats);
    check("pkt_cnt", pkt_cnt, m_pkts);
    if (fire) check("wr_data", wr_data, mbuf[0]);
    if (wr_en) wr_log.push_back(wr_data);
    acc = s_tvalid && m_tready && !rst;
    @(posedge wr_clk);
    if (rst) begin
      mbuf.delete();
      m_tready = 1'b0;
      m_prog   = 1'b0;
      m_beats  = '0;
      m_pkts   = '0;
    end else begin
      if (fire) begin
        m_beats = m_beats + 32'd1;
        if (mbuf[0][DW]) m_pkts = m_pkts + 16'd1;
        void'(mbuf.pop_front());
      end
      if (acc) begin
        mbuf.push_back({s_tlast, s_tdata});
        acc_total++;
      end
      m_tready = (mbuf.size() < 2);
      m_prog   = (int'(fifo_cnt_wr_synced) >= PF);
    end
    @(negedge wr_clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic f);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    wr_full  = f;
  endtask

  int base;

  initial begin
    pf_tab[0] = '{cnt: 3'd0, exp_pf: 1'b0};
    pf_tab[1] = '{cnt: 3'd1, exp_pf: 1'b0};
    pf_tab[2] = '{cnt: 3'd2, exp_pf: 1'b0};
    pf_tab[3] = '{cnt: 3'd3, exp_pf: 1'b1};
    pf_tab[4] = '{cnt: 3'd4, exp_pf: 1'b1};

    // Initial reset: DUT state is unknown before the first edges, so no checks yet
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    step();
    step();

    // Reset release: ready reads 0 for one cycle, then 1
    rst = 1'b0;
    #1 check("rel_tready0", s_tready, 1'b0);
    step();
    #1 check("rel_tready1", s_tready, 1'b1);

    // Test 1: three back-to-back beats
    base = wr_log.size();
    drive(1'b1, 32'h11, 1'b0, 1'b0); step();
    drive(1'b1, 32'h22, 1'b0, 1'b0); step();
    drive(1'b1, 32'h33, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);  step();
    step();
    check("t1_nwr", wr_log.size() - base, 3);
    if (wr_log.size() >= base + 3) begin
      check("t1_d0", wr_log[base], {1'b0, 32'h11});
      check("t1_d1", wr_log[base+1], {1'b0, 32'h22});
      check("t1_d2", wr_log[base+2], {1'b1, 32'h33});
    end
    check("t1_beats", beat_cnt, 32'd3);
    check("t1_pkts", pkt_cnt, 16'd1);

    // Test 2: wr_full held, continuous valid -> two beats taken, then ready drops
    base = wr_log.size();
    drive(1'b1, 32'hA1, 1'b0, 1'b1); step();
    drive(1'b1, 32'hA2, 1'b1, 1'b1); step();
    #1 check("t2_tready_lo", s_tready, 1'b0);
    drive(1'b1, 32'hA3, 1'b0, 1'b1); step();
    check("t2_no_wr", wr_log.size() - base, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
    #1 check("t2_tready_back", s_tready, 1'b1);
    step();
    step();
    check("t2_nwr", wr_log.size() - base, 2);
    if (wr_log.size() >= base + 2) begin
      check("t2_d0", wr_log[base], {1'b0, 32'hA1});
      check("t2_d1", wr_log[base+1], {1'b1, 32'hA2});
    end

    // Test 3: in ONE, wr_full rises with an accept -> TWO, ready drops next cycle
    base = wr_log.size();
    drive(1'b1, 32'hB1, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB2, 1'b0, 1'b1); step();
    #1 check("t3_tready_lo", s_tready, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
    step();
    step();
    check("t3_nwr", wr_log.size() - base, 2);
    if (wr_log.size() >= base + 2) begin
      check("t3_d0", wr_log[base], {1'b0, 32'hB1});
      check("t3_d1", wr_log[base+1], {1'b0, 32'hB2});
    end

    // Test 4: prog_full threshold sweep
    foreach (pf_tab[i]) begin
      fifo_cnt_wr_synced = pf_tab[i].cnt;
      step();
      #1 check($sformatf("t4_pf_cnt%0d", pf_tab[i].cnt), prog_full, pf_tab[i].exp_pf);
    end
    fifo_cnt_wr_synced = '0;
    step();

    // Test 5: reset while in TWO with wr_full held; buffered beats must vanish
    drive(1'b1, 32'hC1, 1'b1, 1'b1); step();
    drive(1'b1, 32'hC2, 1'b0, 1'b1); step();
    step();
    base = wr_log.size();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("t5_wren0", wr_en, 1'b0);
    check("t5_beats", beat_cnt, 32'd0);
    check("t5_pkts", pkt_cnt, 16'd0);
    step();
    #1 check("t5_tready", s_tready, 1'b1);
    step();
    step();
    check("t5_no_stale", wr_log.size() - base, 0);

    // Test 6: randomized stream
    acc_total = 0;
    base = wr_log.size();
    for (int n = 0; n < 10000; n++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom();
      s_tlast  = ($urandom_range(0, 3) == 0);
      wr_full  = ($urandom_range(0, 9) < 3);
      fifo_cnt_wr_synced = CW'($urandom_range(0, DEPTH));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step();
    check("t6_drained", mbuf.size(), 0);
    check("t6_count", wr_log.size() - base, acc_total);
    check("t6_beats", beat_cnt, m_beats);
    check("t6_pkts", pkt_cnt, m_pkts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
